dec_entry_parser: RTL and testbench



---
 rtl/dec_entry_pkg.sv | 41 ++++
 rtl/div_const_seq.sv | 55 +++++
 rtl/dec_entry_parser.sv | 196 +++++++++++++++++++
 tb/tb_dec_entry_parser.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_entry_pkg.sv
// Shared types and constants for the decimal command-entry parser.
package dec_entry_pkg;

  localparam int unsigned ACC_W = 17;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIGITS,
    S_DIV,
    S_COMMIT
  } state_t;

  typedef enum logic {
    TGT_TRIG,
    TGT_CTRIG
  } target_t;

  localparam logic [7:0] CR       = 8'h0D;
  localparam logic [7:0] LF       = 8'h0A;
  localparam logic [7:0] ESC      = 8'h1B;
  localparam logic [7:0] SPACE    = 8'h20;
  localparam logic [7:0] CHAR_0   = 8'h30;
  localparam logic [7:0] CHAR_9   = 8'h39;
  localparam logic [7:0] CHAR_T   = 8'h54;
  localparam logic [7:0] CHAR_C   = 8'h43;
  localparam logic [7:0] CASE_BIT = 8'h20;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= CHAR_0) && (c <= CHAR_9);
  endfunction

  function automatic logic is_eol(input logic [7:0] c);
    return (c == CR) || (c == LF);
  endfunction

  // Case-insensitive letter match; only the letter and its lowercase map here.
  function automatic logic is_letter(input logic [7:0] c, input logic [7:0] upper);
    return (c | CASE_BIT) == (upper | CASE_BIT);
  endfunction

endpackage

// File: rtl/div_const_seq.sv
// Sequential restoring divider by a constant: one quotient bit per cycle,
// MSB first, fixed ACC_W-cycle latency after start. done_c is high during
// the cycle whose closing edge produces the final quotient bit.
module div_const_seq
  import dec_entry_pkg::*;
#(
  parameter int unsigned DIVISOR = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ACC_W-1:0] dividend,
  output logic             done_c,
  output logic [ACC_W-1:0] quotient
);

  localparam int unsigned REM_W = $clog2(DIVISOR + 1) + 1;
  localparam int unsigned CNT_W = $clog2(ACC_W + 1);

  logic [REM_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [REM_W-1:0] trial_c;
  logic             ge_c;

  // Trial subtraction: shift the next dividend bit into the partial remainder.
  always_comb begin
    trial_c = {rem_q[REM_W-2:0], quotient[ACC_W-1]};
    ge_c    = trial_c >= REM_W'(DIVISOR);
    done_c  = busy_q && (cnt_q == CNT_W'(1));
  end

  // Dividend shifts out of the top of quotient while quotient bits shift in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      quotient <= '0;
    end else if (start) begin
      rem_q    <= '0;
      cnt_q    <= CNT_W'(ACC_W);
      busy_q   <= 1'b1;
      quotient <= dividend;
    end else if (busy_q) begin
      rem_q    <= ge_c ? (trial_c - REM_W'(DIVISOR)) : trial_c;
      quotient <= {quotient[ACC_W-2:0], ge_c};
      cnt_q    <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dec_entry_parser.sv
// Decimal command-entry parser: "T<mV>" / "C<count>" terminated by CR/LF,
// converted to binary and committed to trig_level / clk_trig_max.
// Optional character echo enabled by defining DEC_ENTRY_ECHO_EN.
module dec_entry_parser
  import dec_entry_pkg::*;
#(
  parameter int unsigned MAX_DIGITS = 5,
  parameter int unsigned OUT_W      = 12,
  parameter int unsigned TRIG_SCALE = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [OUT_W-1:0] trig_level,
  output logic [OUT_W-1:0] clk_trig_max,
  output logic             upd,
  output logic             err,
  output logic             sat
`ifdef DEC_ENTRY_ECHO_EN
  ,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
`endif
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int unsigned MUL_W = ACC_W + 3;
  localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'((2 ** OUT_W) - 1);

  state_t           state_q, state_d;
  target_t          target_q, target_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] trig_d, ctrig_d;
  logic             upd_d, err_d, sat_d;
  logic             rdy_q, rdy_d;
  logic             accept_c;
  logic             div_start_c;
  logic             div_done_c;
  logic [ACC_W-1:0] quotient;
  logic [ACC_W-1:0] result_c;
  logic [MUL_W-1:0] acc_x10_c;

  assign accept_c = rx_valid && rx_ready;

  div_const_seq #(
    .DIVISOR (TRIG_SCALE)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_c),
    .dividend (acc_q),
    .done_c   (div_done_c),
    .quotient (quotient)
  );

  // Next-state, datapath and pulse decode.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    trig_d      = trig_level;
    ctrig_d     = clk_trig_max;
    upd_d       = 1'b0;
    err_d       = 1'b0;
    sat_d       = 1'b0;
    div_start_c = 1'b0;
    acc_x10_c   = {acc_q, 3'b000} + {2'b00, acc_q, 1'b0};
    result_c    = (target_q == TGT_TRIG) ? quotient : acc_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (is_letter(rx_data, CHAR_T)) begin
            target_d = TGT_TRIG;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_DIGITS;
          end else if (is_letter(rx_data, CHAR_C)) begin
            target_d = TGT_CTRIG;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_DIGITS;
          end else if (!(is_eol(rx_data) || (rx_data == SPACE))) begin
            err_d = 1'b1;
          end
        end
      end
      S_DIGITS: begin
        if (accept_c) begin
          if (is_digit(rx_data)) begin
            if (cnt_q == CNT_W'(MAX_DIGITS)) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else begin
              acc_d = ACC_W'(acc_x10_c + MUL_W'(rx_data[3:0]));
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (is_eol(rx_data)) begin
            if (cnt_q == '0) begin
              err_d   = 1'b1;
              state_d = S_IDLE;
            end else if (target_q == TGT_TRIG) begin
              div_start_c = 1'b1;
              state_d     = S_DIV;
            end else begin
              state_d = S_COMMIT;
            end
          end else if (rx_data == ESC) begin
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_DIV: begin
        if (div_done_c) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (result_c > OUT_MAX) begin
          result_c = OUT_MAX;
          sat_d    = 1'b1;
        end
        if (target_q == TGT_TRIG) begin
          trig_d = OUT_W'(result_c);
        end else begin
          ctrig_d = OUT_W'(result_c);
        end
        upd_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    rdy_d = (state_d == S_IDLE) || (state_d == S_DIGITS);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      target_q     <= TGT_TRIG;
      acc_q        <= '0;
      cnt_q        <= '0;
      trig_level   <= '0;
      clk_trig_max <= '0;
      upd          <= 1'b0;
      err          <= 1'b0;
      sat          <= 1'b0;
      rdy_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      trig_level   <= trig_d;
      clk_trig_max <= ctrig_d;
      upd          <= upd_d;
      err          <= err_d;
      sat          <= sat_d;
      rdy_q        <= rdy_d;
    end
  end

`ifdef DEC_ENTRY_ECHO_EN
  logic [7:0] echo_q;
  logic       echo_full_q;

  // One-entry echo buffer; holds off rx while a pending echo cannot drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_q      <= '0;
      echo_full_q <= 1'b0;
    end else if (accept_c) begin
      echo_q      <= rx_data;
      echo_full_q <= 1'b1;
    end else if (echo_full_q && tx_ready) begin
      echo_full_q <= 1'b0;
    end
  end

  assign tx_data  = echo_q;
  assign tx_valid = echo_full_q;
  assign rx_ready = rdy_q && (!echo_full_q || tx_ready);
`else
  assign rx_ready = rdy_q;
`endif

endmodule

// File: tb/tb_dec_entry_parser.sv
// Self-checking bench for dec_entry_parser: directed cases plus random
// commands checked against a character-level reference model.
`timescale 1ns/1ps
module tb_dec_entry_parser;
  import dec_entry_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [11:0] trig_level;
  logic [11:0] clk_trig_max;
  logic        upd, err, sat;
`ifdef DEC_ENTRY_ECHO_EN
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  echo_log[$];
`endif

  int checks = 0;
  int errors = 0;
  int upd_seen = 0, err_seen = 0, sat_seen = 0, overlap = 0;

  // Reference model state
  int m_trig = 0, m_ctrig = 0;
  int exp_upd = 0, exp_err = 0, exp_sat = 0;
  bit m_in = 0, m_ctgt = 0;
  int m_val = 0, m_nd = 0;
  bit m_commit = 0, m_sat_now = 0, m_err_now = 0;

  dec_entry_parser dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .trig_level   (trig_level),
    .clk_trig_max (clk_trig_max),
    .upd          (upd),
    .err          (err),
    .sat          (sat)
`ifdef DEC_ENTRY_ECHO_EN
    ,
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
`endif
  );

  always #5 clk = ~clk;

  // Pulse bookkeeping sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      upd_seen += int'(upd);
      err_seen += int'(err);
      sat_seen += int'(sat);
      if ((upd && err) || (sat && err) || (sat && !upd)) overlap++;
    end
  end

`ifdef DEC_ENTRY_ECHO_EN
  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready) echo_log.push_back(tx_data);
  end
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Command semantics: letter selects target, digits accumulate, EOL commits
  task automatic model_char(input logic [7:0] c);
    int res;
    bit eol;
    m_commit = 0; m_sat_now = 0; m_err_now = 0;
    eol = (c == 8'h0D) || (c == 8'h0A);
    if (!m_in) begin
      if (c == "T" || c == "t") begin
        m_in = 1; m_ctgt = 0; m_val = 0; m_nd = 0;
      end else if (c == "C" || c == "c") begin
        m_in = 1; m_ctgt = 1; m_val = 0; m_nd = 0;
      end else if (!(eol || c == " ")) begin
        m_err_now = 1;
      end
    end else if (c >= "0" && c <= "9") begin
      if (m_nd == 5) begin
        m_err_now = 1; m_in = 0;
      end else begin
        m_val = m_val * 10 + int'(c - "0");
        m_nd++;
      end
    end else if (eol) begin
      if (m_nd == 0) begin
        m_err_now = 1;
      end else begin
        res = m_ctgt ? m_val : m_val / 3;
        if (res > 4095) begin
          res = 4095; m_sat_now = 1;
        end
        if (m_ctgt) m_ctrig = res; else m_trig = res;
        m_commit = 1;
      end
      m_in = 0;
    end else if (c == 8'h1B) begin
      m_in = 0;
    end else begin
      m_err_now = 1; m_in = 0;
    end
    exp_err += int'(m_err_now);
    exp_upd += int'(m_commit);
    exp_sat += int'(m_sat_now);
  endtask

  task automatic wait_commit();
    int lat = 0;
    bit got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 8 && !m_ctgt) check("rx_ready_in_div", rx_ready, 0);
      if (upd) got = 1;
    end
    check("commit_latency", lat, m_ctgt ? 1 : 18);
    check("sat_with_upd", sat, m_sat_now);
    if (m_ctgt) check("clk_trig_max_commit", clk_trig_max, m_ctrig);
    else        check("trig_level_commit", trig_level, m_trig);
  endtask

  task automatic send_char(input logic [7:0] c, input bit modeled);
    int n = 0;
    @(negedge clk);
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", rx_ready, 1);
    rx_data  = c;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    if (modeled) begin
      model_char(c);
      check("err_after_char", err, m_err_now);
      if (m_commit) wait_commit();
    end
  endtask

  task automatic send_str(input string s, input logic [7:0] term);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b1);
    if (term != 8'h00) send_char(term, 1'b1);
    check("trig_level_hold", trig_level, m_trig);
    check("clk_trig_max_hold", clk_trig_max, m_ctrig);
  endtask

  initial begin
    logic [7:0] cmd[$];
    logic [7:0] letters[4];
    int nd;
    int upd_before;
    letters[0] = "T"; letters[1] = "t"; letters[2] = "C"; letters[3] = "c";

    // Reset values
    #1 rst_n = 1'b0;
    #20;
    check("rst_trig_level", trig_level, 0);
    check("rst_clk_trig_max", clk_trig_max, 0);
    check("rst_rx_ready", rx_ready, 0);
    check("rst_pulses", {upd, err, sat}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rx_ready_after_release", rx_ready, 1);

    // Main directed commands
    send_str("T1500", CR);
    send_str("t1501", LF);
    send_str("C250", CR);
    send_str("T99999", CR);
    send_str("C5000", CR);

    // Rejected commands
    send_str("T12a", 8'h00);
    send_str("T123456", 8'h00);
    send_str("T", CR);
    send_str("X", 8'h00);
    send_str(" ", LF);

    // Silent abort
    upd_before = upd_seen;
    send_str("T12", ESC);
    repeat (20) @(posedge clk);
    #1 check("esc_no_upd", upd_seen, upd_before);

    // Reset mid-division
    send_str("T3000", 8'h00);
    send_char(CR, 1'b0);
    repeat (5) @(posedge clk);
    #1 check("rx_ready_div_before_rst", rx_ready, 0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_div_trig", trig_level, 0);
    check("rst_mid_div_ctrig", clk_trig_max, 0);
    check("rst_mid_div_ready", rx_ready, 0);
    m_trig = 0; m_ctrig = 0; m_in = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rx_ready_after_rst2", rx_ready, 1);
    upd_before = upd_seen;
    repeat (25) @(posedge clk);
    #1 check("no_commit_after_rst", upd_seen, upd_before);
    send_str("T300", CR);
    check("trig_after_rst", trig_level, 100);

    // Random commands
    for (int i = 0; i < 30; i++) begin
      cmd.delete();
      cmd.push_back(letters[$urandom_range(0, 3)]);
      nd = ($urandom_range(0, 9) == 0) ? 6 : $urandom_range(1, 5);
      for (int j = 0; j < nd; j++) cmd.push_back(8'(8'h30 + $urandom_range(0, 9)));
      case ($urandom_range(0, 7))
        0:       cmd.push_back(8'h23);
        1:       cmd.push_back(ESC);
        2, 3, 4: cmd.push_back(CR);
        default: cmd.push_back(LF);
      endcase
      foreach (cmd[j]) send_char(cmd[j], 1'b1);
      check("rand_trig_level", trig_level, m_trig);
      check("rand_clk_trig_max", clk_trig_max, m_ctrig);
    end

`ifdef DEC_ENTRY_ECHO_EN
    // Echo back-pressure
    @(negedge clk);
    tx_ready = 1'b0;
    echo_log.delete();
    send_char("T", 1'b1);
    repeat (3) @(negedge clk);
    check("echo_valid_held", tx_valid, 1);
    check("echo_data_held", tx_data, 8'h54);
    check("rx_ready_blocked", rx_ready, 0);
    tx_ready = 1'b1;
    send_char("9", 1'b1);
    repeat (3) @(negedge clk);
    check("echo_count", echo_log.size(), 2);
    check("echo_first", (echo_log.size() >= 2) ? echo_log[0] : 8'h00, 8'h54);
    check("echo_second", (echo_log.size() >= 2) ? echo_log[1] : 8'h00, 8'h39);
    send_str("5", CR);
`endif

    repeat (4) @(posedge clk);
    #1;
    check("total_upd", upd_seen, exp_upd);
    check("total_err", err_seen, exp_err);
    check("total_sat", sat_seen, exp_sat);
    check("pulse_overlap", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
